// File: rtl/i3c_cfg_pkg.sv
// Shared types and helpers for the I3C descriptor loader.
package i3c_cfg_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HANDOFF = 3'd2,
    ST_RUN     = 3'd3,
    ST_FINISH  = 3'd4
  } desc_ld_state_e;

  localparam int unsigned NUM_DESC_BYTES = 8;

  typedef logic [2:0] desc_idx_t;

  // Select byte idx of a 64-bit descriptor; byte k = desc[8k+7:8k].
  function automatic logic [7:0] desc_byte(input logic [63:0] desc, input desc_idx_t idx);
    logic [5:0] lsb_s;
    lsb_s     = {idx, 3'b000};
    desc_byte = desc[lsb_s +: 8];
  endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
// Priority: clr > load > en. The count saturates at all-ones.
module cfg_wait_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Counter register: clear, load or advance by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == term);

endmodule

// File: rtl/i3c_desc_loader.sv
// Host-side sequencer: writes one 64-bit descriptor into the I3C register
// file byte by byte, hands ownership back, runs the controller and waits
// for completion or timeout.
module i3c_desc_loader
  import i3c_cfg_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = 12'd1000,
  parameter int unsigned WR_HOLD     = 2,
  parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst_n,
  input  logic        i_desc_valid,
  output logic        o_desc_ready,
  input  logic [63:0] i_desc,
  input  logic        i_abort,
  input  logic        i_ctrl_done,
  output logic [7:0]  o_regf_config,
  output logic [11:0] o_regf_wr_address_config,
  output logic        o_regf_wr_en_config,
  output logic        o_regf_rd_en_config,
  output logic        o_data_config_mux_sel,
  output logic        o_controller_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout
);

  localparam logic [19:0] HOLD_TERM = 20'(WR_HOLD);
  localparam logic [19:0] ONE_20    = 20'd1;

  desc_ld_state_e state_r, state_n_s;
  desc_idx_t      idx_r, idx_n_s;
  logic [63:0]    desc_r, desc_n_s;

  logic hold_clr_s, hold_load_s, hold_en_s, hold_tc_s;
  logic run_clr_s, run_load_s, run_en_s, run_tc_s;

  logic [7:0]  regf_config_r, regf_config_n_s;
  logic [11:0] regf_addr_r, regf_addr_n_s;
  logic        regf_wr_en_r, regf_wr_en_n_s;
  logic        mux_sel_r, mux_sel_n_s;
  logic        ctrl_en_r, ctrl_en_n_s;
  logic        done_r, done_n_s;
  logic        timeout_r, timeout_n_s;

  cfg_wait_timer #(.W(20)) u_hold_timer (
    .clk      (i_sdr_clk),
    .rst_n    (i_sdr_rst_n),
    .clr      (hold_clr_s),
    .load     (hold_load_s),
    .load_val (ONE_20),
    .en       (hold_en_s),
    .term     (HOLD_TERM),
    .tc       (hold_tc_s)
  );

  cfg_wait_timer #(.W(20)) u_run_timer (
    .clk      (i_sdr_clk),
    .rst_n    (i_sdr_rst_n),
    .clr      (run_clr_s),
    .load     (run_load_s),
    .load_val (ONE_20),
    .en       (run_en_s),
    .term     (TIMEOUT_CYC),
    .tc       (run_tc_s)
  );

  // Next-state, byte index, descriptor capture and timer controls.
  always_comb begin
    state_n_s   = state_r;
    idx_n_s     = idx_r;
    desc_n_s    = desc_r;
    hold_clr_s  = 1'b0;
    hold_load_s = 1'b0;
    hold_en_s   = 1'b0;
    run_clr_s   = 1'b0;
    run_load_s  = 1'b0;
    run_en_s    = 1'b0;
    timeout_n_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_desc_valid) begin
          state_n_s   = ST_LOAD;
          desc_n_s    = i_desc;
          idx_n_s     = 3'd0;
          hold_load_s = 1'b1;
        end else begin
          hold_clr_s = 1'b1;
          run_clr_s  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          state_n_s  = ST_IDLE;
          desc_n_s   = 64'd0;
          hold_clr_s = 1'b1;
        end else if (hold_tc_s) begin
          if (idx_r == 3'd7) begin
            state_n_s  = ST_HANDOFF;
            hold_clr_s = 1'b1;
          end else begin
            idx_n_s     = idx_r + 3'd1;
            hold_load_s = 1'b1;
          end
        end else begin
          hold_en_s = 1'b1;
        end
      end
      ST_HANDOFF: begin
        if (i_abort) begin
          state_n_s = ST_IDLE;
          desc_n_s  = 64'd0;
        end else begin
          state_n_s  = ST_RUN;
          run_load_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_n_s = ST_IDLE;
          desc_n_s  = 64'd0;
          run_clr_s = 1'b1;
        end else if (i_ctrl_done) begin
          state_n_s = ST_FINISH;
        end else if (run_tc_s) begin
          state_n_s   = ST_IDLE;
          timeout_n_s = 1'b1;
        end else begin
          run_en_s = 1'b1;
        end
      end
      ST_FINISH: begin
        if (i_abort) begin
          desc_n_s = 64'd0;
        end else begin
          desc_n_s = desc_r;
        end
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so
  // every registered output lines up with the state it belongs to.
  always_comb begin
    regf_wr_en_n_s  = (state_n_s == ST_LOAD);
    mux_sel_n_s     = (state_n_s == ST_LOAD);
    ctrl_en_n_s     = (state_n_s == ST_RUN);
    done_n_s        = (state_n_s == ST_FINISH);
    regf_addr_n_s   = 12'd0;
    regf_config_n_s = 8'd0;
    if (state_n_s == ST_LOAD) begin
      regf_addr_n_s   = BASE_ADDR + {9'd0, idx_n_s};
      regf_config_n_s = desc_byte(desc_n_s, idx_n_s);
    end else begin
      regf_addr_n_s   = 12'd0;
      regf_config_n_s = 8'd0;
    end
  end

  // State, index and captured descriptor registers.
  always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
    if (!i_sdr_rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      desc_r  <= 64'd0;
    end else begin
      state_r <= state_n_s;
      idx_r   <= idx_n_s;
      desc_r  <= desc_n_s;
    end
  end

  // Registered outputs toward the register file and controller.
  always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
    if (!i_sdr_rst_n) begin
      regf_config_r <= 8'd0;
      regf_addr_r   <= 12'd0;
      regf_wr_en_r  <= 1'b0;
      mux_sel_r     <= 1'b0;
      ctrl_en_r     <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      regf_config_r <= regf_config_n_s;
      regf_addr_r   <= regf_addr_n_s;
      regf_wr_en_r  <= regf_wr_en_n_s;
      mux_sel_r     <= mux_sel_n_s;
      ctrl_en_r     <= ctrl_en_n_s;
      done_r        <= done_n_s;
      timeout_r     <= timeout_n_s;
    end
  end

  assign o_desc_ready             = (state_r == ST_IDLE);
  assign o_busy                   = (state_r != ST_IDLE);
  assign o_regf_config            = regf_config_r;
  assign o_regf_wr_address_config = regf_addr_r;
  assign o_regf_wr_en_config      = regf_wr_en_r;
  assign o_regf_rd_en_config      = 1'b0;
  assign o_data_config_mux_sel    = mux_sel_r;
  assign o_controller_en          = ctrl_en_r;
  assign o_done                   = done_r;
  assign o_timeout                = timeout_r;

endmodule

// File: tb/tb_i3c_desc_loader.sv
// Directed self-checking bench for i3c_desc_loader (WR_HOLD=2, TIMEOUT_CYC=60).
module tb_i3c_desc_loader;

  logic        i_sdr_clk;
  logic        i_sdr_rst_n;
  logic        i_desc_valid;
  logic        o_desc_ready;
  logic [63:0] i_desc;
  logic        i_abort;
  logic        i_ctrl_done;
  logic [7:0]  o_regf_config;
  logic [11:0] o_regf_wr_address_config;
  logic        o_regf_wr_en_config;
  logic        o_regf_rd_en_config;
  logic        o_data_config_mux_sel;
  logic        o_controller_en;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] DESC_A = 64'h04030201_99030018;
  localparam logic [63:0] DESC_B = 64'h11223344_55667788;

  logic [7:0] exp_bytes [8] = '{8'h18, 8'h00, 8'h03, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04};

  i3c_desc_loader #(
    .BASE_ADDR   (12'd1000),
    .WR_HOLD     (2),
    .TIMEOUT_CYC (20'd60)
  ) dut (
    .i_sdr_clk                (i_sdr_clk),
    .i_sdr_rst_n              (i_sdr_rst_n),
    .i_desc_valid             (i_desc_valid),
    .o_desc_ready             (o_desc_ready),
    .i_desc                   (i_desc),
    .i_abort                  (i_abort),
    .i_ctrl_done              (i_ctrl_done),
    .o_regf_config            (o_regf_config),
    .o_regf_wr_address_config (o_regf_wr_address_config),
    .o_regf_wr_en_config      (o_regf_wr_en_config),
    .o_regf_rd_en_config      (o_regf_rd_en_config),
    .o_data_config_mux_sel    (o_data_config_mux_sel),
    .o_controller_en          (o_controller_en),
    .o_busy                   (o_busy),
    .o_done                   (o_done),
    .o_timeout                (o_timeout)
  );

  initial i_sdr_clk = 1'b0;
  always #5 i_sdr_clk = ~i_sdr_clk;

  task automatic tick();
    @(posedge i_sdr_clk);
    #1;
  endtask

  // Offer a descriptor for one edge; returns in cycle 1 after acceptance.
  task automatic accept(input logic [63:0] d);
    i_desc       = d;
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
    i_desc       = 64'd0;
  endtask

  task automatic test_reset();
    i_sdr_rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (o_desc_ready !== 1'b1 || o_busy !== 1'b0 || o_regf_config !== 8'd0 ||
        o_regf_wr_address_config !== 12'd0 || o_regf_wr_en_config !== 1'b0 ||
        o_regf_rd_en_config !== 1'b0 || o_data_config_mux_sel !== 1'b0 ||
        o_controller_en !== 1'b0 || o_done !== 1'b0 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b busy=%b cfg=%h addr=%0d wr=%b rd=%b mux=%b en=%b done=%b to=%b, required ready=1 others 0",
               o_desc_ready, o_busy, o_regf_config, o_regf_wr_address_config, o_regf_wr_en_config,
               o_regf_rd_en_config, o_data_config_mux_sel, o_controller_en, o_done, o_timeout);
    end
    i_sdr_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_abort_idle();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_desc_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_idle: busy=%b ready=%b, required busy=0 ready=1", o_busy, o_desc_ready);
    end
  endtask

  // Nominal load followed by completion 50 cycles into RUN.
  task automatic test_load_and_done();
    checks++;
    if (o_desc_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_accept: got %b, required 1", o_desc_ready);
    end
    accept(DESC_A);
    checks++;
    if (o_desc_ready !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_accept: ready=%b busy=%b, required ready=0 busy=1", o_desc_ready, o_busy);
    end
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (o_regf_wr_en_config !== 1'b1 || o_data_config_mux_sel !== 1'b1 ||
          o_regf_wr_address_config !== (12'd1000 + 12'((k - 1) / 2)) ||
          o_regf_config !== exp_bytes[(k - 1) / 2] || o_controller_en !== 1'b0) begin
        failures++;
        $display("FAIL load_cycle_%0d: wr=%b mux=%b addr=%0d data=%h en=%b, required wr=1 mux=1 addr=%0d data=%h en=0",
                 k, o_regf_wr_en_config, o_data_config_mux_sel, o_regf_wr_address_config, o_regf_config,
                 o_controller_en, 12'd1000 + 12'((k - 1) / 2), exp_bytes[(k - 1) / 2]);
      end
      if (k != 16) tick();
    end
    tick();  // cycle 17: handoff
    checks++;
    if (o_regf_wr_en_config !== 1'b0 || o_data_config_mux_sel !== 1'b0 || o_controller_en !== 1'b0) begin
      failures++;
      $display("FAIL handoff_acc17: wr=%b mux=%b en=%b, required 0 0 0",
               o_regf_wr_en_config, o_data_config_mux_sel, o_controller_en);
    end
    tick();  // cycle 18: RUN cycle 1
    checks++;
    if (o_controller_en !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_en_acc18: en=%b busy=%b, required 1 1", o_controller_en, o_busy);
    end
    for (int k = 0; k < 49; k++) tick();  // RUN cycle 50
    checks++;
    if (o_controller_en !== 1'b1 || o_done !== 1'b0 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL run_cycle50: en=%b done=%b to=%b, required 1 0 0", o_controller_en, o_done, o_timeout);
    end
    i_ctrl_done = 1'b1;
    tick();
    i_ctrl_done = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_controller_en !== 1'b0 || o_timeout !== 1'b0 || o_desc_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b en=%b to=%b ready=%b, required 1 0 0 0",
               o_done, o_controller_en, o_timeout, o_desc_ready);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_desc_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done: done=%b ready=%b busy=%b, required 0 1 0", o_done, o_desc_ready, o_busy);
    end
  endtask

  task automatic test_timeout();
    int seen_bad;
    seen_bad = 0;
    accept(DESC_B);
    for (int k = 0; k < 17; k++) tick();  // RUN cycle 1
    for (int k = 1; k <= 60; k++) begin
      if (o_timeout !== 1'b0 || o_done !== 1'b0 || o_controller_en !== 1'b1) seen_bad++;
      if (k != 60) tick();
    end
    checks++;
    if (seen_bad != 0) begin
      failures++;
      $display("FAIL run_before_timeout: %0d bad cycles, required 0", seen_bad);
    end
    tick();
    checks++;
    if (o_timeout !== 1'b1 || o_done !== 1'b0 || o_controller_en !== 1'b0 || o_desc_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: to=%b done=%b en=%b ready=%b, required 1 0 0 1",
               o_timeout, o_done, o_controller_en, o_desc_ready);
    end
    accept(DESC_B);
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b1 || o_regf_config !== 8'h88 ||
        o_regf_wr_address_config !== 12'd1000) begin
      failures++;
      $display("FAIL accept_after_timeout: to=%b busy=%b data=%h addr=%0d, required 0 1 88 1000",
               o_timeout, o_busy, o_regf_config, o_regf_wr_address_config);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tick();
  endtask

  task automatic test_done_timeout_collision();
    accept(DESC_A);
    for (int k = 0; k < 17; k++) tick();  // RUN cycle 1
    for (int k = 1; k < 60; k++) tick();  // RUN cycle 60 = terminal count
    i_ctrl_done = 1'b1;
    tick();
    i_ctrl_done = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL collision: done=%b to=%b, required done=1 to=0", o_done, o_timeout);
    end
    tick();
  endtask

  task automatic test_abort_load();
    int wr_seen;
    int byte4_seen;
    int done_seen;
    wr_seen = 0; byte4_seen = 0; done_seen = 0;
    accept(DESC_A);
    for (int k = 0; k < 6; k++) tick();  // cycle 7: byte 3 first hold cycle
    checks++;
    if (o_regf_wr_address_config !== 12'd1003 || o_regf_config !== 8'h99) begin
      failures++;
      $display("FAIL abort_at_byte3_pre: addr=%0d data=%h, required 1003 99",
               o_regf_wr_address_config, o_regf_config);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (o_regf_wr_en_config !== 1'b0 || o_data_config_mux_sel !== 1'b0 ||
        o_controller_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: wr=%b mux=%b en=%b busy=%b done=%b, required all 0",
               o_regf_wr_en_config, o_data_config_mux_sel, o_controller_en, o_busy, o_done);
    end
    i_ctrl_done = 1'b1;  // ignored outside RUN
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_regf_wr_en_config === 1'b1) wr_seen++;
      if (o_regf_wr_en_config === 1'b1 && o_regf_wr_address_config === 12'd1004) byte4_seen++;
      if (o_done === 1'b1 || o_controller_en === 1'b1) done_seen++;
    end
    i_ctrl_done = 1'b0;
    checks++;
    if (wr_seen != 0 || byte4_seen != 0 || done_seen != 0) begin
      failures++;
      $display("FAIL after_abort: writes=%0d byte4=%0d done_or_en=%0d, required 0 0 0",
               wr_seen, byte4_seen, done_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    accept(DESC_B);
    for (int k = 0; k < 22; k++) tick();
    checks++;
    if (o_controller_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_run: en=%b, required 1", o_controller_en);
    end
    #2;
    i_sdr_rst_n = 1'b0;
    #1;
    checks++;
    if (o_desc_ready !== 1'b1 || o_busy !== 1'b0 || o_controller_en !== 1'b0 ||
        o_regf_wr_en_config !== 1'b0 || o_data_config_mux_sel !== 1'b0 ||
        o_done !== 1'b0 || o_timeout !== 1'b0 || o_regf_config !== 8'd0 ||
        o_regf_wr_address_config !== 12'd0) begin
      failures++;
      $display("FAIL async_reset_mid_run: ready=%b busy=%b en=%b wr=%b mux=%b done=%b to=%b cfg=%h addr=%0d, required ready=1 others 0",
               o_desc_ready, o_busy, o_controller_en, o_regf_wr_en_config, o_data_config_mux_sel,
               o_done, o_timeout, o_regf_config, o_regf_wr_address_config);
    end
    #2;
    i_sdr_rst_n = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_controller_en !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b en=%b, required 0 0", o_busy, o_controller_en);
    end
  endtask

  initial begin
    i_sdr_rst_n  = 1'b1;
    i_desc_valid = 1'b0;
    i_desc       = 64'd0;
    i_abort      = 1'b0;
    i_ctrl_done  = 1'b0;
    test_reset();
    test_abort_idle();
    test_load_and_done();
    test_timeout();
    test_done_timeout_collision();
    test_abort_load();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
